// File: rtl/serial_add_pkg.sv
// Shared encodings and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StRun  = RUN,
        StDone = DONE
    } state_e;

    // Bit counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout
    );

endinterface

// File: rtl/full_adder_1b.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: captures operands on start, adds LSB first one bit per cycle,
// then commits sum/cout and pulses done.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic               clk,
    input logic               rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_co;

    full_adder_1b u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                s_sr_d  = {fa_s, s_sr_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (cnt_q == LAST_BIT) begin
                    // Last bit: commit the fully assembled word, counter parks at 0.
                    state_d = StDone;
                    sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation from an idle DUT; optionally re-pulses start mid-run.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input bit repulse);
        logic [W:0] r;
        r = ref_add(av, bv, ci);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom_range(0, 1));
        for (int i = 0; i < int'(W); i++) begin
            chk("busy_in_run", bus.busy, 1);
            chk("done_in_run", bus.done, 0);
            if (i % 8 == 0) begin
                chk("sum_hold_run", bus.sum, last_sum);
                chk("cout_hold_run", bus.cout, last_cout);
            end
            if (repulse && i == 5) begin
                bus.start = 1'b1;
                bus.a     = ~av;
                bus.b     = bv ^ 32'h5A5A_5A5A;
                bus.cin   = ~ci;
            end
            if (repulse && i == 6) bus.start = 1'b0;
            @(negedge clk);
        end
        chk("done_pulse", bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        chk("sum_result", bus.sum, r[W-1:0]);
        chk("cout_result", bus.cout, r[W]);
        last_sum  = r[W-1:0];
        last_cout = r[W];
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("busy_idle", bus.busy, 0);
        chk("sum_hold_idle", bus.sum, last_sum);
    endtask

    initial begin
        logic [W-1:0] qa [3];
        logic [W-1:0] qb [3];
        logic         qc [3];
        logic [W:0]   r;
        int           n;
        int           last_cyc;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        rst_n = 1'b1;

        run_op(32'hABCD_1234, 32'hDCBA_4312, 1'b0, 1'b0);
        run_op(32'h1234_ABCD, 32'h4321_DCBA, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op(32'h0F0F_F0F0, 32'h1111_2222, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), k[0]);
        end

        // Abort in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'h8765_4321;
        bus.b     = 32'h1357_9BDF;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_abort", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_sum", bus.sum, 0);
        chk("abort_cout", bus.cout, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 0);
        end
        rst_n     = 1'b1;
        last_sum  = '0;
        last_cout = 1'b0;
        run_op(32'h8765_4321, 32'h1357_9BDF, 1'b1, 1'b0);

        // start held high: three back-to-back operations.
        for (int k = 0; k < 3; k++) begin
            qa[k] = W'($urandom);
            qb[k] = W'($urandom);
            qc[k] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = qa[0];
        bus.b     = qb[0];
        bus.cin   = qc[0];
        n         = 0;
        last_cyc  = 0;
        for (int cyc = 0; cyc < 3 * (int'(W) + 2) + 10 && n < 3; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                r = ref_add(qa[n], qb[n], qc[n]);
                chk("b2b_sum", bus.sum, r[W-1:0]);
                chk("b2b_cout", bus.cout, r[W]);
                if (n > 0) chk("b2b_spacing", cyc - last_cyc, W + 2);
                last_cyc = cyc;
                n++;
                if (n < 3) begin
                    bus.a   = qa[n];
                    bus.b   = qb[n];
                    bus.cin = qc[n];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        chk("b2b_count", n, 3);
        @(negedge clk);
        chk("b2b_idle_busy", bus.busy, 0);
        chk("b2b_idle_done", bus.done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and sum width in bits (legal range 2..64).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a new addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  addend A; captured on the accepted start edge.
REQ-006 Port: b  input  WIDTH  addend B; captured on the accepted start edge.
REQ-007 Port: cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  one-cycle pulse when a result has been committed.
REQ-010 Port: sum  output  WIDTH  last committed sum, registered.
REQ-011 Port: cout  output  1  last committed carry-out, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE -> RUN SHALL occur on the edge where start=1; a, b and cin load into internal shift registers and a carry flop, and the bit counter clears to 0.
REQ-014 RUN SHALL process one bit per cycle, LSB first, through one 1-bit full adder: sum bit = a0^b0^c, next carry = majority(a0,b0,c).
REQ-015 In RUN, the operand registers SHALL shift right by one, the sum bit SHALL enter the MSB of an internal sum shift register, and the counter SHALL increment.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1 (counter = WIDTH-1).
REQ-017 On that same edge, the assembled sum SHALL be written to sum and the final carry to cout.
REQ-018 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-019 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-020 Latency: if start is accepted at edge k, sum and cout are valid and done=1 after edge k+WIDTH, and the FSM is back in IDLE after edge k+WIDTH+1.
REQ-021 start SHALL be ignored in RUN and DONE, with no queuing; a and b may change freely after acceptance.
REQ-022 sum and cout SHALL hold their values from completion until the next completion; they SHALL NOT change during RUN.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; overflow is reported only through cout.
REQ-024 The counter width SHALL be clog2(WIDTH); the counter SHALL never wrap within an operation.
REQ-025 start held high continuously SHALL give back-to-back operations, each started on the edge after DONE (period WIDTH+2 cycles).

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and clear to 0: busy, done, sum, cout, counter, carry and all shift registers.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse, and sum and cout SHALL read 0.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where it is sampled high.

Structure
REQ-029 Package serial_add_pkg SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the default WIDTH and the counter-width function.
REQ-030 Sub-module full_adder_1b (inputs a, b, ci; outputs s, co) SHALL be instantiated exactly once as the only arithmetic element.
REQ-031 All sequential logic SHALL use a single clk domain with asynchronous rst_n.

Verification
REQ-032 a=32'hABCD1234, b=32'hDCBA4312, cin=0, start pulse -> done after 32 edges; sum=32'h88875546, cout=1.
REQ-033 a=32'h1234ABCD, b=32'h4321DCBA, cin=1 -> sum=32'h55568888, cout=0; busy high for exactly 32 cycles.
REQ-034 a=32'hFFFFFFFF, b=0, cin=1 -> sum=0, cout=1; a=0, b=0, cin=0 -> sum=0, cout=0, done still pulses.
REQ-035 start re-pulsed during RUN with different operands -> ignored; the first result completes unchanged, and sum holds its previous value throughout RUN.
REQ-036 rst_n asserted at RUN bit 10 -> busy=0, done never pulses, sum=0, cout=0; a new start afterwards gives the correct result.
REQ-037 start held high for 3 operations -> done pulses spaced 34 cycles apart, each result matches a reference model.
